// File: rtl/card_board_ctl.sv
// Card board responder: per-card state/colour store, renderer snapshot, and click hit-testing.
// Optional CARD_PEEK_EN adds a peek input that shows covered cards as discovered and blocks clicks.
module card_board_ctl #(
  parameter int N_CARDS = 16,
  parameter int ADDR_W  = 5,
  parameter int COLOR_W = 12,
  parameter int COLS    = 4,
  parameter int X0      = 64,
  parameter int Y0      = 48,
  parameter int CARD_W  = 96,
  parameter int CARD_H  = 96,
  parameter int PITCH_X = 128,
  parameter int PITCH_Y = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    num_of_cards,
  input  logic                 color_wr_en,
  input  logic [ADDR_W-1:0]    color_wr_addr,
  input  logic [COLOR_W-1:0]   color_wr_data,
  input  logic                 write_card_en,
  input  logic [ADDR_W-1:0]    write_card_address,
  input  logic [1:0]           write_card_state,
  input  logic                 update_cards_en,
  output logic [2*N_CARDS-1:0] card_states,
  output logic                 update_done,
  input  logic                 wait_for_click_en,
  input  logic                 mouse_left,
  input  logic [11:0]          mouse_xpos,
  input  logic [11:0]          mouse_ypos,
`ifdef CARD_PEEK_EN
  input  logic                 peek,
`endif
  output logic                 card_pressed,
  output logic [ADDR_W-1:0]    card_clicked_address,
  output logic [COLOR_W-1:0]   card_clicked_color,
  output logic                 busy
);

  localparam int IDX_W = (N_CARDS > 1) ? $clog2(N_CARDS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} fsm_t;

  logic [1:0]         st_mem  [N_CARDS];
  logic [COLOR_W-1:0] col_mem [N_CARDS];
  logic [2*N_CARDS-1:0] snap_src;
  logic upd_req_reg, update_done_reg;
  logic [2*N_CARDS-1:0] card_states_reg;

  fsm_t fsm_reg, fsm_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [COL_W-1:0]   col_reg, col_next;
  logic [12:0]        x_reg, x_next, y_reg, y_next;
  logic [12:0]        ox_reg, ox_next, oy_reg, oy_next;
  logic               ml_prev_reg;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [COLOR_W-1:0] color_reg, color_next;
  logic               click_block;
  logic               hit, last_card;

  // Address decode against the slot index also drops out-of-range addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CARDS; i++) begin
        st_mem[i]  <= 2'b00;
        col_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CARDS; i++) begin
        if (color_wr_en && color_wr_addr == ADDR_W'(i)) begin
          col_mem[i] <= color_wr_data;
          st_mem[i]  <= 2'b01;
        end
        if (write_card_en && write_card_address == ADDR_W'(i))
          st_mem[i] <= write_card_state;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_CARDS; gi++) begin : g_snap
`ifdef CARD_PEEK_EN
      assign snap_src[2*gi +: 2] = (peek && st_mem[gi] == 2'b01) ? 2'b11 : st_mem[gi];
`else
      assign snap_src[2*gi +: 2] = st_mem[gi];
`endif
    end
  endgenerate

`ifdef CARD_PEEK_EN
  assign click_block = peek;
`else
  assign click_block = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_req_reg     <= 1'b0;
      update_done_reg <= 1'b0;
      card_states_reg <= '0;
    end else begin
      upd_req_reg     <= update_cards_en;
      update_done_reg <= upd_req_reg;
      if (upd_req_reg)
        card_states_reg <= snap_src;
    end
  end

  assign card_states = card_states_reg;
  assign update_done = update_done_reg;

  assign hit = (x_reg >= ox_reg) && (x_reg < ox_reg + 13'(CARD_W)) &&
               (y_reg >= oy_reg) && (y_reg < oy_reg + 13'(CARD_H));
  assign last_card = (ADDR_W'(idx_reg) == num_of_cards - ADDR_W'(1)) ||
                     (idx_reg == IDX_W'(N_CARDS - 1));

  always_comb begin
    fsm_next   = fsm_reg;
    idx_next   = idx_reg;
    col_next   = col_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    ox_next    = ox_reg;
    oy_next    = oy_reg;
    addr_next  = addr_reg;
    color_next = color_reg;
    case (fsm_reg)
      IDLE: begin
        if (wait_for_click_en && mouse_left && !ml_prev_reg && !click_block) begin
          fsm_next = SCAN;
          x_next   = {1'b0, mouse_xpos};
          y_next   = {1'b0, mouse_ypos};
          idx_next = '0;
          col_next = '0;
          ox_next  = 13'(X0);
          oy_next  = 13'(Y0);
        end
      end
      SCAN: begin
        if (!wait_for_click_en || num_of_cards == '0) begin
          fsm_next = IDLE;
        end else if (hit) begin
          // Only covered cards are clickable; the store read is pre-write.
          if (st_mem[idx_reg] == 2'b01) begin
            fsm_next   = REPORT;
            addr_next  = ADDR_W'(idx_reg);
            color_next = col_mem[idx_reg];
          end else begin
            fsm_next = IDLE;
          end
        end else if (last_card) begin
          fsm_next = IDLE;
        end else begin
          idx_next = idx_reg + IDX_W'(1);
          if (col_reg == COL_W'(COLS - 1)) begin
            col_next = '0;
            ox_next  = 13'(X0);
            oy_next  = oy_reg + 13'(PITCH_Y);
          end else begin
            col_next = col_reg + COL_W'(1);
            ox_next  = ox_reg + 13'(PITCH_X);
          end
        end
      end
      REPORT:  fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg     <= IDLE;
      idx_reg     <= '0;
      col_reg     <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      ox_reg      <= '0;
      oy_reg      <= '0;
      ml_prev_reg <= 1'b0;
      addr_reg    <= '0;
      color_reg   <= '0;
    end else begin
      fsm_reg     <= fsm_next;
      idx_reg     <= idx_next;
      col_reg     <= col_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      ox_reg      <= ox_next;
      oy_reg      <= oy_next;
      ml_prev_reg <= mouse_left;
      addr_reg    <= addr_next;
      color_reg   <= color_next;
    end
  end

  assign card_pressed         = (fsm_reg == REPORT);
  assign busy                 = (fsm_reg == SCAN);
  assign card_clicked_address = addr_reg;
  assign card_clicked_color   = color_reg;

endmodule

// File: tb/tb_card_board_ctl.sv
// Directed bench for card_board_ctl: store writes, snapshots, click resolution, reset mid-scan, optional peek.
module tb_card_board_ctl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  num_of_cards;
  logic        color_wr_en;
  logic [4:0]  color_wr_addr;
  logic [11:0] color_wr_data;
  logic        write_card_en;
  logic [4:0]  write_card_address;
  logic [1:0]  write_card_state;
  logic        update_cards_en;
  logic [31:0] card_states;
  logic        update_done;
  logic        wait_for_click_en;
  logic        mouse_left;
  logic [11:0] mouse_xpos, mouse_ypos;
  logic        card_pressed;
  logic [4:0]  card_clicked_address;
  logic [11:0] card_clicked_color;
  logic        busy;
`ifdef CARD_PEEK_EN
  logic        peek;
`endif

  int checks = 0;
  int errors = 0;

  card_board_ctl dut (
    .clk(clk), .rst_n(rst_n), .num_of_cards(num_of_cards),
    .color_wr_en(color_wr_en), .color_wr_addr(color_wr_addr), .color_wr_data(color_wr_data),
    .write_card_en(write_card_en), .write_card_address(write_card_address),
    .write_card_state(write_card_state), .update_cards_en(update_cards_en),
    .card_states(card_states), .update_done(update_done),
    .wait_for_click_en(wait_for_click_en), .mouse_left(mouse_left),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
`ifdef CARD_PEEK_EN
    .peek(peek),
`endif
    .card_pressed(card_pressed), .card_clicked_address(card_clicked_address),
    .card_clicked_color(card_clicked_color), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_colors();
    for (int i = 0; i < 16; i++) begin
      color_wr_en = 1'b1; color_wr_addr = 5'(i); color_wr_data = 12'hA00 | 12'(i);
      step();
    end
    color_wr_en = 1'b0;
  endtask

  task automatic write_state(input int addr, input logic [1:0] st);
    write_card_en = 1'b1; write_card_address = 5'(addr); write_card_state = st;
    step();
    write_card_en = 1'b0;
  endtask

  // Press at (x,y); returns whether a pulse was seen, cycles busy, and edges from press to pulse.
  task automatic click(input int x, input int y, output logic pressed, output int busy_cyc, output int lat);
    logic done;
    pressed = 1'b0; busy_cyc = 0; lat = 0; done = 1'b0;
    mouse_xpos = 12'(x); mouse_ypos = 12'(y); mouse_left = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      step();
      if (card_pressed) begin pressed = 1'b1; lat = n + 1; end
      if (busy) busy_cyc++;
      else done = 1'b1;
    end
    if (!done) check("click_timeout", 32'd1, 32'd0);
    mouse_left = 1'b0;
    step();
  endtask

  task automatic snapshot();
    update_cards_en = 1'b1;
    step();
    update_cards_en = 1'b0;
    step();
  endtask

  logic p;
  int   bc, lat;

  initial begin
    rst_n = 1'b0; num_of_cards = 5'd16; color_wr_en = 0; color_wr_addr = 0; color_wr_data = 0;
    write_card_en = 0; write_card_address = 0; write_card_state = 0; update_cards_en = 0;
    wait_for_click_en = 0; mouse_left = 0; mouse_xpos = 0; mouse_ypos = 0;
`ifdef CARD_PEEK_EN
    peek = 1'b0;
`endif
    step(); step();
    check("rst_busy", 32'(busy), 0);
    check("rst_pressed", 32'(card_pressed), 0);
    check("rst_states", card_states, 0);
    check("rst_done", 32'(update_done), 0);
    check("rst_addr", 32'(card_clicked_address), 0);
    check("rst_color", 32'(card_clicked_color), 0);
    rst_n = 1'b1;
    step();

    // Test 1: card 0
    load_colors();
    wait_for_click_en = 1'b1;
    click(70, 50, p, bc, lat);
    $display("txn click(70,50) pressed=%0d lat=%0d busy=%0d", p, lat, bc);
    check("t1_pressed", 32'(p), 1);
    check("t1_lat", 32'(lat), 2);
    check("t1_addr", 32'(card_clicked_address), 0);
    check("t1_color", 32'(card_clicked_color), 32'hA00);

    // Test 2: discovered card 5 ignored, covered card 5 reported
    write_state(5, 2'b11);
    click(200, 180, p, bc, lat);
    $display("txn click(200,180) disc pressed=%0d busy=%0d", p, bc);
    check("t2_no_pulse", 32'(p), 0);
    check("t2_busy", 32'(bc), 6);
    check("t2_addr_held", 32'(card_clicked_address), 0);
    write_state(5, 2'b01);
    click(200, 180, p, bc, lat);
    $display("txn click(200,180) cov pressed=%0d lat=%0d", p, lat);
    check("t2_pressed", 32'(p), 1);
    check("t2_lat", 32'(lat), 7);
    check("t2_addr", 32'(card_clicked_address), 5);
    check("t2_color", 32'(card_clicked_color), 32'hA05);

    // Test 3: gap and outside grid
    click(165, 50, p, bc, lat);
    $display("txn click(165,50) pressed=%0d busy=%0d", p, bc);
    check("t3_gap_pulse", 32'(p), 0);
    check("t3_gap_busy", 32'(bc), 16);
    click(700, 500, p, bc, lat);
    $display("txn click(700,500) pressed=%0d busy=%0d", p, bc);
    check("t3_out_pulse", 32'(p), 0);
    check("t3_out_busy", 32'(bc), 16);

    // Test 4: write + snapshot in the same cycle
    write_card_en = 1'b1; write_card_address = 5'd3; write_card_state = 2'b10; update_cards_en = 1'b1;
    step();
    write_card_en = 1'b0; update_cards_en = 1'b0;
    check("t4_done_early", 32'(update_done), 0);
    step();
    $display("txn snapshot states=%08h done=%0d", card_states, update_done);
    check("t4_done", 32'(update_done), 1);
    check("t4_states", card_states, 32'h5555_5595);
    step();
    check("t4_done_pulse", 32'(update_done), 0);

    // Colour and state to the same card; out-of-range state write
    color_wr_en = 1'b1; color_wr_addr = 5'd7; color_wr_data = 12'h123;
    write_card_en = 1'b1; write_card_address = 5'd7; write_card_state = 2'b10;
    step();
    color_wr_en = 1'b0;
    write_card_address = 5'd20; write_card_state = 2'b11;
    step();
    write_card_en = 1'b0;
    snapshot();
    $display("txn snapshot states=%08h", card_states);
    check("t4_both_oob", card_states, 32'h5555_9595);
    write_state(7, 2'b01);
    click(450, 200, p, bc, lat);
    $display("txn click(450,200) pressed=%0d addr=%0d color=%03h", p, card_clicked_address, card_clicked_color);
    check("t4_c7_pressed", 32'(p), 1);
    check("t4_c7_addr", 32'(card_clicked_address), 7);
    check("t4_c7_color", 32'(card_clicked_color), 32'h123);

    // Fewer cards in play
    num_of_cards = 5'd0;
    click(70, 50, p, bc, lat);
    $display("txn n=0 click(70,50) pressed=%0d busy=%0d", p, bc);
    check("n0_pulse", 32'(p), 0);
    check("n0_busy", 32'(bc), 1);
    num_of_cards = 5'd4;
    click(200, 180, p, bc, lat);
    $display("txn n=4 click(200,180) pressed=%0d busy=%0d", p, bc);
    check("n4_pulse", 32'(p), 0);
    check("n4_busy", 32'(bc), 4);
    num_of_cards = 5'd16;

    // Test 5: reset mid-scan
    mouse_xpos = 12'd165; mouse_ypos = 12'd50; mouse_left = 1'b1;
    step(); step(); step();
    check("t5_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    $display("txn reset mid-scan busy=%0d states=%08h", busy, card_states);
    check("t5_busy", 32'(busy), 0);
    check("t5_states", card_states, 0);
    check("t5_pressed", 32'(card_pressed), 0);
    check("t5_addr", 32'(card_clicked_address), 0);
    step();
    rst_n = 1'b1; mouse_left = 1'b0;
    step();
    click(70, 50, p, bc, lat);
    $display("txn click(70,50) empty pressed=%0d", p);
    check("t5_empty_pulse", 32'(p), 0);
    load_colors();
    click(70, 50, p, bc, lat);
    $display("txn click(70,50) reload pressed=%0d color=%03h", p, card_clicked_color);
    check("t5_pressed_after", 32'(p), 1);
    check("t5_color_after", 32'(card_clicked_color), 32'hA00);

`ifdef CARD_PEEK_EN
    // Test 6: peek
    write_state(2, 2'b10);
    peek = 1'b1;
    snapshot();
    $display("txn peek snapshot states=%08h", card_states);
    check("t6_peek_states", card_states, 32'hFFFF_FFEF);
    click(70, 50, p, bc, lat);
    check("t6_peek_pulse", 32'(p), 0);
    check("t6_peek_busy", 32'(bc), 0);
    peek = 1'b0;
    snapshot();
    $display("txn raw snapshot states=%08h", card_states);
    check("t6_raw_states", card_states, 32'h5555_5565);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
